// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the sequencer (master) and the memory
// system (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps IDLE/FETCH/DECODE/EXEC/MEM/WB, shares one
// memory port between fetch and data access, counts retirements, traps on faults.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 br_taken,
  multicycle_ctrl_if.master    bus,
  output logic                 ir_we,
  output logic                 mdr_we,
  output logic                 reg_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 retire,
  output logic [CNT_W-1:0]     instret,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // The wait counter only has to reach TIMEOUT_CYC-1; width 1 when disabled.
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic is_load, is_store, is_branch, is_jal, is_jalr, is_legal;
  logic timeout_hit;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_legal  = (opcode == OP_LUI)  || (opcode == OP_AUIPC) || is_jal   ||
                     is_jalr             || is_branch            || is_load  ||
                     is_store            || (opcode == OP_IMM)   || (opcode == OP_REG);

  // Last permitted wait cycle with no response; a same-cycle mem_ready still wins.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  assign state_o = state;

  // Strobes decode from state and the live handshake so ir_we/mdr_we land in
  // the very cycle the memory responds.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    reg_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    retire       = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        ir_we       = bus.mem_ready;
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? PC_IMM : PC_PLUS4;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            mdr_we = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        if (is_jal)       pc_sel = PC_IMM;
        else if (is_jalr) pc_sel = PC_ALU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (timeout_hit) begin
            wait_cnt   <= '0;
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state <= S_EXEC;
          end else begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) state <= S_MEM;
          else if (is_branch)      state <= run ? S_FETCH : S_IDLE;
          else                     state <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            if (is_store) state <= run ? S_FETCH : S_IDLE;
            else          state <= S_WB;
          end else if (timeout_hit) begin
            wait_cnt   <= '0;
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          state <= run ? S_FETCH : S_IDLE;
        end
        S_TRAP: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
